// File: rtl/apb_master_fsm_if.sv
// apb_master_fsm_if: request/response handshake and APB bus signals of the AXI4-Lite-to-APB master sequencer.
interface apb_master_fsm_if #(
  parameter int c_apb_num_slaves = 1
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_write;
  logic [31:0]                 req_addr;
  logic [31:0]                 req_wdata;
  logic [3:0]                  req_wstrb;
  logic [2:0]                  req_prot;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [31:0]                 rsp_rdata;
  logic [1:0]                  rsp_resp;
  logic [31:0]                 m_apb_paddr;
  logic [c_apb_num_slaves-1:0] m_apb_psel;
  logic                        m_apb_penable;
  logic                        m_apb_pwrite;
  logic [31:0]                 m_apb_pwdata;
  logic [3:0]                  m_apb_pstrb;
  logic [2:0]                  m_apb_pprot;
  logic [c_apb_num_slaves-1:0] m_apb_pready;
  logic [c_apb_num_slaves-1:0] m_apb_pslverr;
  logic [31:0]                 apb_rdata;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, req_prot, rsp_ready,
    input  m_apb_pready, m_apb_pslverr, apb_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_resp,
    output m_apb_paddr, m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pwdata, m_apb_pstrb, m_apb_pprot
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, req_prot, rsp_ready,
    output m_apb_pready, m_apb_pslverr, apb_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
    input  m_apb_paddr, m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pwdata, m_apb_pstrb, m_apb_pprot
  );
endinterface

// File: rtl/apb_master_fsm.sv
// apb_master_fsm: APB3/APB4 master sequencer turning one decoded request into one APB transfer and one AXI-coded response.
module apb_master_fsm #(
  parameter int c_apb_num_slaves = 1,
  parameter int c_sel_lsb        = 12,
  parameter int c_apb_timeout    = 0
) (
  input logic            s_axi_aclk,
  input logic            s_axi_areset,
  apb_master_fsm_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  typedef logic [c_apb_num_slaves-1:0] sel_t;
  localparam logic [4:0]  c_n        = 5'(c_apb_num_slaves);
  localparam logic [31:0] c_tmo_last = 32'(c_apb_timeout - 1);
  state_t      state, state_d;
  logic [3:0]  idx, idx_d, req_idx;
  logic [31:0] cnt, cnt_d;
  logic [31:0] paddr, paddr_d, pwdata, pwdata_d, rdata, rdata_d;
  logic [3:0]  pstrb, pstrb_d;
  logic [2:0]  pprot, pprot_d;
  logic [1:0]  resp, resp_d;
  sel_t        psel, psel_d;
  logic        penable, penable_d, pwrite, pwrite_d, rvalid, rvalid_d;
  logic [15:0] rdy16, err16;
  assign req_idx           = bus.req_addr[c_sel_lsb +: 4];
  assign rdy16             = 16'(bus.m_apb_pready);
  assign err16             = 16'(bus.m_apb_pslverr);
  assign bus.req_ready     = state == IDLE;
  assign bus.rsp_valid     = rvalid;
  assign bus.rsp_rdata     = rdata;
  assign bus.rsp_resp      = resp;
  assign bus.m_apb_paddr   = paddr;
  assign bus.m_apb_psel    = psel;
  assign bus.m_apb_penable = penable;
  assign bus.m_apb_pwrite  = pwrite;
  assign bus.m_apb_pwdata  = pwdata;
  assign bus.m_apb_pstrb   = pstrb;
  assign bus.m_apb_pprot   = pprot;
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt;
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    pstrb_d   = pstrb;
    pprot_d   = pprot;
    pwrite_d  = pwrite;
    psel_d    = psel;
    penable_d = penable;
    rvalid_d  = rvalid;
    rdata_d   = rdata;
    resp_d    = resp;
    case (state)
      IDLE: if (bus.req_valid) begin
        paddr_d  = bus.req_addr;
        pwdata_d = bus.req_wdata;
        pstrb_d  = bus.req_write ? bus.req_wstrb : 4'd0;
        pprot_d  = bus.req_prot;
        pwrite_d = bus.req_write;
        idx_d    = req_idx;
        if ({1'b0, req_idx} < c_n) begin
          psel_d    = sel_t'(16'd1 << req_idx);
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = SETUP;
        end else begin
          rvalid_d = 1'b1;
          rdata_d  = '0;
          resp_d   = 2'b11;
          state_d  = RESP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: if (rdy16[idx]) begin
        rdata_d   = pwrite ? 32'd0 : bus.apb_rdata;
        resp_d    = err16[idx] ? 2'b10 : 2'b00;
        psel_d    = '0;
        penable_d = 1'b0;
        rvalid_d  = 1'b1;
        state_d   = RESP;
      end else begin
        cnt_d = cnt + 32'd1;
        // a stuck slave is abandoned with SLVERR once the wait budget is spent
        if (c_apb_timeout != 0 && cnt == c_tmo_last) begin
          psel_d    = '0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = '0;
          resp_d    = 2'b10;
          state_d   = RESP;
        end
      end
      RESP: if (bus.rsp_ready) begin
        rvalid_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset)
    if (s_axi_areset) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      pprot   <= '0;
      pwrite  <= 1'b0;
      psel    <= '0;
      penable <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      resp    <= '0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      cnt     <= cnt_d;
      paddr   <= paddr_d;
      pwdata  <= pwdata_d;
      pstrb   <= pstrb_d;
      pprot   <= pprot_d;
      pwrite  <= pwrite_d;
      psel    <= psel_d;
      penable <= penable_d;
      rvalid  <= rvalid_d;
      rdata   <= rdata_d;
      resp    <= resp_d;
    end
endmodule

// File: tb/tb_apb_master_fsm.sv
// tb_apb_master_fsm: directed and randomized transfers against a transaction-level expectation model.
module tb_apb_master_fsm;
  localparam int N   = 4;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  always #5 clk = ~clk;
  apb_master_fsm_if #(.c_apb_num_slaves(N)) bus ();
  apb_master_fsm #(.c_apb_num_slaves(N), .c_sel_lsb(12), .c_apb_timeout(TMO)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic junk_slaves();
    bus.m_apb_pready  = 4'($urandom);
    bus.m_apb_pslverr = 4'($urandom);
  endtask
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input logic [2:0] pr, input int waits, input logic er, input logic [31:0] rd, input int hold);
    logic [3:0]  ix     = a[15:12];
    bit          hit    = ix < N;
    bit          tmo    = hit && waits >= TMO;
    int          rc     = !hit ? 1 : (tmo ? 2 + TMO : 3 + waits);
    logic [1:0]  resp_e = !hit ? 2'b11 : (tmo || er) ? 2'b10 : 2'b00;
    logic [31:0] rd_e   = (!hit || tmo || w) ? 32'd0 : rd;
    logic [3:0]  sel_e  = hit ? 4'(1 << ix) : 4'd0;
    logic [3:0]  rdy, err;
    chk("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = wd;
    bus.req_wstrb = ws; bus.req_prot = pr; bus.apb_rdata = rd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    bus.req_wstrb = 4'($urandom); bus.req_prot = 3'($urandom); bus.req_write = 1'($urandom);
    for (int c = 1; c < rc; c++) begin
      chk("psel", 32'(bus.m_apb_psel), 32'(sel_e));
      chk("penable", 32'(bus.m_apb_penable), 32'(c >= 2));
      chk("paddr", bus.m_apb_paddr, a);
      chk("pwrite", 32'(bus.m_apb_pwrite), 32'(w));
      chk("pwdata", bus.m_apb_pwdata, wd);
      chk("pstrb", 32'(bus.m_apb_pstrb), w ? 32'(ws) : 0);
      chk("pprot", 32'(bus.m_apb_pprot), 32'(pr));
      chk("rsp_valid_busy", 32'(bus.rsp_valid), 0);
      chk("req_ready_busy", 32'(bus.req_ready), 0);
      rdy = 4'($urandom); err = 4'($urandom);
      rdy[ix[1:0]] = (c == 1) ? 1'b1 : (c - 2 == waits);
      err[ix[1:0]] = er;
      bus.m_apb_pready = rdy; bus.m_apb_pslverr = err;
      @(posedge clk); #1;
    end
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", 32'(bus.rsp_valid), 1);
      chk("rsp_resp", 32'(bus.rsp_resp), 32'(resp_e));
      chk("rsp_rdata", bus.rsp_rdata, rd_e);
      chk("psel_resp", 32'(bus.m_apb_psel), 0);
      chk("penable_resp", 32'(bus.m_apb_penable), 0);
      chk("req_ready_resp", 32'(bus.req_ready), 0);
      junk_slaves();
      bus.apb_rdata = $urandom;
      bus.rsp_ready = (h == hold);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_done", 32'(bus.rsp_valid), 0);
    chk("req_ready_done", 32'(bus.req_ready), 1);
  endtask
  initial begin
    logic [31:0] a;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_wstrb = 0; bus.req_prot = 0; bus.rsp_ready = 0;
    bus.m_apb_pready = 0; bus.m_apb_pslverr = 0; bus.apb_rdata = 0;
    #12;
    chk("rst_psel", 32'(bus.m_apb_psel), 0);
    chk("rst_penable", 32'(bus.m_apb_penable), 0);
    chk("rst_paddr", bus.m_apb_paddr, 0);
    chk("rst_pwdata", bus.m_apb_pwdata, 0);
    chk("rst_pctl", {25'd0, bus.m_apb_pwrite, bus.m_apb_pstrb, bus.m_apb_pprot}, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_resp}, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    @(posedge clk); #1; rst = 0;
    txn(0, 32'h0000_0010, 32'h0, 4'h0, 3'd0, 0, 0, 32'hDEAD_BEEF, 0);
    txn(1, 32'h0000_2004, 32'h1234_5678, 4'hF, 3'd2, 3, 0, 32'hCAFE_F00D, 0);
    txn(0, 32'h0000_1008, 32'h0, 4'h0, 3'd1, 0, 1, 32'hA5A5_0001, 0);
    txn(1, 32'h0000_5000, 32'h1111_2222, 4'h3, 3'd0, 0, 0, 32'h0, 0);
    txn(0, 32'h0000_3000, 32'h0, 4'h0, 3'd7, 20, 0, 32'h7777_7777, 0);
    txn(0, 32'h0000_300C, 32'h0, 4'hF, 3'd4, 7, 0, 32'h0BAD_CAFE, 5);
    txn(1, 32'hFFFF_F000, 32'h3, 4'h1, 3'd0, 0, 0, 32'h0, 2);
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'h0000_3040;
    @(posedge clk); #1; bus.req_valid = 0; bus.m_apb_pready = 0;
    @(posedge clk); #1;
    chk("pre_rst_penable", 32'(bus.m_apb_penable), 1);
    rst = 1; #1;
    chk("mid_rst_psel", 32'(bus.m_apb_psel), 0);
    chk("mid_rst_penable", 32'(bus.m_apb_penable), 0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_paddr", bus.m_apb_paddr, 0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 1);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      a[15:12] = 4'($urandom_range(0, 5));
      txn(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom), int'($urandom_range(0, 10)),
          1'($urandom), $urandom, int'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
